// File: rtl/clock_ctrl.sv
// Programmable clock-enable generator: free-run, single-step and counted-burst
// modes over a loadable integer divider; every output comes straight from a flop.
module clock_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             stop_i,
    input  logic             burst_start_i,
    input  logic [15:0]      burst_len_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             tick_o,
    output logic [1:0]       state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      tick_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_BURST = 2'd3;
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [15:0]      rem_q, rem_d, rem_base_s;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [15:0]      tick_count_q, tick_count_d;
    logic             step_prev_q;
    logic             step_edge_s;

    // Next-state logic; tick/done are derived from the *next* state and count
    // so that the registered outputs line up with the registered state.
    always_comb begin
        step_edge_s = step_i & ~step_prev_q;
        cnt_inc_s   = (cnt_q == ratio_q - ONE) ? '0 : cnt_q + ONE;
        state_d     = state_q;
        cnt_d       = cnt_inc_s;
        ratio_d     = ratio_q;
        rem_base_s  = rem_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                rem_base_s = 16'd0;
                if (div_load_i) begin
                    ratio_d = (div_i == '0) ? ONE : div_i;
                end else begin
                    ratio_d = ratio_q;
                end
                if (burst_start_i && (burst_len_i != 16'd0)) begin
                    state_d    = ST_BURST;
                    rem_base_s = burst_len_i;
                end else if (step_edge_s) begin
                    state_d = ST_STEP;
                end else if (run_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!run_i || stop_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (stop_i || tick_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_BURST: begin
                // rem_q is already decremented for the tick currently on the output
                if (stop_i || (tick_q && (rem_q == 16'd0))) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    rem_base_s = 16'd0;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                rem_base_s = 16'd0;
            end
        endcase
        tick_d = (state_d != ST_IDLE) && (cnt_d == ratio_d - ONE);
        done_d = tick_d && ((state_d == ST_STEP) ||
                            ((state_d == ST_BURST) && (rem_base_s == 16'd1)));
        if (state_d == ST_BURST && tick_d) begin
            rem_d = rem_base_s - 16'd1;
        end else if (state_d == ST_BURST) begin
            rem_d = rem_base_s;
        end else begin
            rem_d = 16'd0;
        end
        busy_d       = (state_d != ST_IDLE);
        tick_count_d = tick_count_q + {15'd0, tick_d};
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ratio_q      <= DIV_W'(DEFAULT_DIV);
            rem_q        <= 16'd0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            tick_count_q <= 16'd0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ratio_q      <= ratio_d;
            rem_q        <= rem_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            tick_count_q <= tick_count_d;
            step_prev_q  <= step_i;
        end
    end

    assign tick_o       = tick_q;
    assign state_o      = state_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign tick_count_o = tick_count_q;

endmodule
